// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared types and constants for the skid-buffered pipeline stage
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int DEF_CTRL_W   = 9;
    localparam int DEF_DATA_W   = 106;
    localparam int DEF_SIGN_IDX = 31;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one storage entry (valid, ctrl, data, neg); clear_ctrl squashes ctrl/valid and keeps data
module pipe_stage_slot
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic              ld_valid,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_neg,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic              o_neg
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              r_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_neg   <= 1'b0;
        end else if (clear_ctrl) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_neg   <= 1'b0;
        end else if (load) begin
            r_valid <= ld_valid;
            r_ctrl  <= ld_ctrl;
            r_data  <= ld_data;
            r_neg   <= ld_neg;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_neg   = r_neg;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer; PIPE_STAGE_STATS_EN adds stall/bubble counters
module pipe_stage_skid
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SIGN_IDX = DEF_SIGN_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_neg,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    state_t r_state, w_state_next;
    logic   r_in_ready;

    logic              w_enq, w_deq;
    logic              w_main_load, w_main_clr, w_main_from_skid;
    logic              w_skid_load, w_skid_clr;
    logic              w_main_valid, w_main_neg;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_skid_valid, w_skid_neg;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    // Handshake decisions depend only on valid/ready, so X data cannot reach state.
    assign w_enq = in_valid && r_in_ready;
    assign w_deq = w_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_TWO);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_clr       = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_clr   = 1'b1;
            w_skid_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_enq) begin
                        w_main_load  = 1'b1;
                        w_state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_enq && w_deq) begin
                        w_main_load  = 1'b1;
                    end else if (w_enq) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_TWO;
                    end else if (w_deq) begin
                        w_main_clr   = 1'b1;
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: begin
                    w_main_clr   = 1'b1;
                    w_skid_clr   = 1'b1;
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (w_main_load),
        .clear_ctrl (w_main_clr),
        .ld_valid   (w_main_from_skid ? w_skid_valid : 1'b1),
        .ld_ctrl    (w_main_from_skid ? w_skid_ctrl  : in_ctrl),
        .ld_data    (w_main_from_skid ? w_skid_data  : in_data),
        .ld_neg     (w_main_from_skid ? w_skid_neg   : in_data[SIGN_IDX]),
        .o_valid    (w_main_valid),
        .o_ctrl     (w_main_ctrl),
        .o_data     (out_data),
        .o_neg      (w_main_neg)
    );

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (w_skid_load),
        .clear_ctrl (w_skid_clr),
        .ld_valid   (1'b1),
        .ld_ctrl    (in_ctrl),
        .ld_data    (in_data),
        .ld_neg     (in_data[SIGN_IDX]),
        .o_valid    (w_skid_valid),
        .o_ctrl     (w_skid_ctrl),
        .o_data     (w_skid_data),
        .o_neg      (w_skid_neg)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign out_neg   = w_main_valid & w_main_neg;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_main_valid && !out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (!w_main_valid)              r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [8:0]   in_ctrl = '0;
    logic [105:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [8:0]   out_ctrl;
    logic [105:0] out_data;
    logic         out_neg;
    logic [15:0]  stall_cnt;
    logic [15:0]  bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .out_neg    (out_neg),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [105:0] mkd(input logic [31:0] k, input logic n);
        logic [105:0] d;
        d = {10'h155, k ^ 32'hA5A5_5A5A, ~k, k};
        d[31] = n;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
        checks++; if (out_ctrl !== 9'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", out_ctrl); end
        checks++; if (out_data !== 106'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
        checks++; if (out_neg !== 1'b0) begin errors++; $display("FAIL rst_neg got %0b exp 0", out_neg); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        checks++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", stall_cnt, bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_ctrl = 9'h1A5; in_data = mkd(32'(i), 1'b1);
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 9'h1A5) begin errors++; $display("FAIL pt_head[%0d] got v=%0b c=%h exp v=1 c=1a5", i, out_valid, out_ctrl); end
            checks++; if (out_data !== mkd(32'(i), 1'b1)) begin errors++; $display("FAIL pt_data[%0d] got %h exp %h", i, out_data, mkd(32'(i), 1'b1)); end
            checks++; if (out_neg !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL pt_neg_rdy[%0d] got n=%0b r=%0b exp 1/1", i, out_neg, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 9'h0 || out_neg !== 1'b0) begin errors++; $display("FAIL pt_drain got v=%0b c=%h n=%0b exp 0/0/0", out_valid, out_ctrl, out_neg); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 9'h0A1; in_data = mkd(32'hA, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 9'h0A1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_a got v=%0b c=%h r=%0b exp 1/0a1/1", out_valid, out_ctrl, in_ready); end
        in_ctrl = 9'h0B2; in_data = mkd(32'hB, 1'b1);
        tick();
        checks++; if (out_ctrl !== 9'h0A1 || out_neg !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got c=%h n=%0b r=%0b exp 0a1/0/0", out_ctrl, out_neg, in_ready); end
        in_ctrl = 9'h0EE; in_data = mkd(32'hE, 1'b1);
        tick();
        checks++; if (out_data !== mkd(32'hA, 1'b0) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got d=%h r=%0b exp %h/0", out_data, in_ready, mkd(32'hA, 1'b0)); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 9'h0B2 || out_neg !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_b got v=%0b c=%h n=%0b r=%0b exp 1/0b2/1/1", out_valid, out_ctrl, out_neg, in_ready); end
        checks++; if (out_data !== mkd(32'hB, 1'b1)) begin errors++; $display("FAIL bp_b_data got %h exp %h", out_data, mkd(32'hB, 1'b1)); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_empty got v=%0b r=%0b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 9'h111; in_data = mkd(32'h5, 1'b1);
        tick();
        in_ctrl = 9'h122; in_data = mkd(32'h6, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_two got r=%0b exp 0", in_ready); end
        flush = 1'b1; out_ready = 1'b1; in_ctrl = 9'h1CC; in_data = mkd(32'hC, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 9'h0 || out_neg !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_out got v=%0b c=%h n=%0b r=%0b exp 0/0/0/1", out_valid, out_ctrl, out_neg, in_ready); end
        checks++; if (out_data !== mkd(32'h5, 1'b1)) begin errors++; $display("FAIL fl_data_held got %h exp %h", out_data, mkd(32'h5, 1'b1)); end
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_ctrl !== 9'h0) begin errors++; $display("FAIL fl_c_dropped[%0d] got v=%0b c=%h exp 0/0", i, out_valid, out_ctrl); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 9'h040; in_data = mkd(32'h40, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            in_ctrl = 9'(9'h040 + i); in_data = mkd(32'(32'h40 + i), i[0]);
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 9'(9'h040 + i) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_head[%0d] got v=%0b c=%h r=%0b exp 1/%h/1", i, out_valid, out_ctrl, in_ready, 9'(9'h040 + i)); end
            checks++; if (out_data !== mkd(32'(32'h40 + i), i[0]) || out_neg !== i[0]) begin errors++; $display("FAIL b2b_data[%0d] got n=%0b d=%h", i, out_neg, out_data); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%0b exp 0", out_valid); end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = mkd(32'h77, 1'b1);
        tick();
        in_data = mkd(32'h78, 1'b1);
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 9'h0 || out_data !== 106'h0 || out_neg !== 1'b0) begin errors++; $display("FAIL rst2_out got v=%0b c=%h n=%0b d=%h exp all 0", out_valid, out_ctrl, out_neg, out_data); end
        checks++; if (in_ready !== 1'b1 || stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin errors++; $display("FAIL rst2_rdy_cnt got r=%0b s=%h b=%h exp 1/0/0", in_ready, stall_cnt, bubble_cnt); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst2_after got v=%0b exp 0", out_valid); end
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b1; in_ctrl = 9'h003; in_data = mkd(32'h99, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL st_start got s=%0d b=%0d exp 0/1", stall_cnt, bubble_cnt); end
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL st_pre_sat got %h exp fffe", stall_cnt); end
        repeat (4466) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'd1) begin errors++; $display("FAIL st_sat got s=%h b=%0d exp ffff/1", stall_cnt, bubble_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'd1) begin errors++; $display("FAIL st_flush got s=%h b=%0d exp ffff/1", stall_cnt, bubble_cnt); end
        tick();
        checks++; if (bubble_cnt !== 16'd2) begin errors++; $display("FAIL st_bubble got %0d exp 2", bubble_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_back_to_back();
        test_reset_in_two();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
